// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, opcodes and instruction decode helper
package jtag_pkg;

    // Conventional 1149.1 TAP state encoding.
    typedef enum logic [3:0] {
        TLR        = 4'hF,
        RTI        = 4'hC,
        SELECT_DR  = 4'h7,
        CAPTURE_DR = 4'h6,
        SHIFT_DR   = 4'h2,
        EXIT1_DR   = 4'h1,
        PAUSE_DR   = 4'h3,
        EXIT2_DR   = 4'h0,
        UPDATE_DR  = 4'h5,
        SELECT_IR  = 4'h4,
        CAPTURE_IR = 4'hE,
        SHIFT_IR   = 4'hA,
        EXIT1_IR   = 4'h9,
        PAUSE_IR   = 4'hB,
        EXIT2_IR   = 4'h8,
        UPDATE_IR  = 4'hD
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    localparam logic [31:0] OPC_IDCODE = 32'd1;
    localparam logic [31:0] OPC_USER   = 32'd8;

    // Map an instruction of width ir_len to the data register it selects.
    // All-ones is BYPASS; every undefined opcode also falls back to BYPASS.
    function automatic dr_sel_e decode_ir(input logic [31:0] ir, input int ir_len);
        logic [31:0] ones;
        ones = (32'd1 << ir_len) - 32'd1;
        if (ir == ones)            return DR_BYPASS;
        else if (ir == OPC_IDCODE) return DR_IDCODE;
        else if (ir == OPC_USER)   return DR_USER;
        else                       return DR_BYPASS;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller state machine
// Ports:
//   TCK       test clock
//   TRST_N    asynchronous active-low reset to Test-Logic-Reset
//   TMS       mode select, sampled on posedge TCK
//   tap_state current controller state
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output tap_state_e tap_state
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) state_q <= TLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:        state_d = TMS ? TLR       : RTI;
            RTI:        state_d = TMS ? SELECT_DR : RTI;
            SELECT_DR:  state_d = TMS ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_d = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_d = TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_d = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_d = TMS ? SELECT_DR : RTI;
            SELECT_IR:  state_d = TMS ? TLR       : CAPTURE_IR;
            CAPTURE_IR: state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_d = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_d = TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_d = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_d = TMS ? SELECT_DR : RTI;
            default:    state_d = TLR;
        endcase
    end

    assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap.sv
// rtl/jtag_tap.sv - JTAG TAP with IR, BYPASS, IDCODE and one user data register
// Ports:
//   TCK, TRST_N      test clock and asynchronous active-low TAP reset
//   TMS, TDI         mode select and serial data in, sampled on posedge TCK
//   TDO, tdo_en      serial data out and pad enable, registered on negedge TCK
//   user_capture     value loaded into the user DR in Capture-DR
//   user_update      user DR contents latched in Update-DR
//   user_update_stb  high for the TCK cycle spent in Update-DR with USER selected
//   tap_state        controller state (jtag_pkg encoding)
//   ir_q             active instruction
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int          IR_LEN      = 4,
    parameter logic [31:0] IDCODE_VAL  = 32'h10A5_E0CF,
    parameter int          USER_DR_LEN = 32
) (
    input  logic                   TCK,
    input  logic                   TRST_N,
    input  logic                   TMS,
    input  logic                   TDI,
    output logic                   TDO,
    output logic                   tdo_en,
    input  logic [USER_DR_LEN-1:0] user_capture,
    output logic [USER_DR_LEN-1:0] user_update,
    output logic                   user_update_stb,
    output logic [3:0]             tap_state,
    output logic [IR_LEN-1:0]      ir_q
);

    localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(OPC_IDCODE);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

    tap_state_e state;
    dr_sel_e    dr_sel;

    logic [IR_LEN-1:0]      ir_shift;
    logic                   bypass_reg;
    logic [31:0]            id_shift;
    logic [USER_DR_LEN-1:0] user_shift;
    logic                   dr_lsb;

    jtag_tap_fsm u_fsm (
        .TCK       (TCK),
        .TRST_N    (TRST_N),
        .TMS       (TMS),
        .tap_state (state)
    );

    assign tap_state = state;
    assign dr_sel    = decode_ir(32'(ir_q), IR_LEN);

    // Shift registers: capture and shift on posedge. Only the selected DR
    // moves, so the other registers keep whatever they last held.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift   <= '0;
            bypass_reg <= 1'b0;
            id_shift   <= '0;
            user_shift <= '0;
        end else begin
            case (state)
                CAPTURE_IR: ir_shift <= IR_CAPTURE;
                SHIFT_IR:   ir_shift <= {TDI, ir_shift[IR_LEN-1:1]};
                CAPTURE_DR: begin
                    case (dr_sel)
                        DR_IDCODE: id_shift   <= IDCODE_VAL;
                        DR_USER:   user_shift <= user_capture;
                        default:   bypass_reg <= 1'b0;
                    endcase
                end
                SHIFT_DR: begin
                    case (dr_sel)
                        DR_IDCODE: id_shift   <= {TDI, id_shift[31:1]};
                        DR_USER:   user_shift <= {TDI, user_shift[USER_DR_LEN-1:1]};
                        default:   bypass_reg <= TDI;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dr_lsb = bypass_reg;
        case (dr_sel)
            DR_IDCODE: dr_lsb = id_shift[0];
            DR_USER:   dr_lsb = user_shift[0];
            default:   dr_lsb = bypass_reg;
        endcase
    end

    // The strobe follows the registered state, so it spans exactly the
    // Update-DR cycle and is low whenever TRST_N forces Test-Logic-Reset.
    assign user_update_stb = (state == UPDATE_DR) && (dr_sel == DR_USER);

    // Negedge stage: instruction/user updates land mid-cycle so they are
    // stable before the next posedge; TDO is retimed so there is no
    // combinational TDI-to-TDO path.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_q        <= IR_IDCODE;
            user_update <= '0;
            TDO         <= 1'b0;
            tdo_en      <= 1'b0;
        end else begin
            if (state == TLR)            ir_q <= IR_IDCODE;
            else if (state == UPDATE_IR) ir_q <= ir_shift;

            if ((state == UPDATE_DR) && (dr_sel == DR_USER))
                user_update <= user_shift;

            tdo_en <= (state == SHIFT_IR) || (state == SHIFT_DR);
            if (state == SHIFT_IR)      TDO <= ir_shift[0];
            else if (state == SHIFT_DR) TDO <= dr_lsb;
            else                        TDO <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap.sv
// tb/tb_jtag_tap.sv - directed irscan/drscan bench for jtag_tap
module tb_jtag_tap;
    import jtag_pkg::*;

    logic        TCK = 1'b0;
    logic        TRST_N;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        tdo_en;
    logic [31:0] user_capture;
    logic [31:0] user_update;
    logic        user_update_stb;
    logic [3:0]  tap_state;
    logic [3:0]  ir_q;

    int n_cmp   = 0;
    int n_bad   = 0;
    int stb_cnt = 0;

    logic [63:0] rd;
    logic        d;

    jtag_tap #(
        .IR_LEN      (4),
        .IDCODE_VAL  (32'h10A5_E0CF),
        .USER_DR_LEN (32)
    ) dut (
        .TCK             (TCK),
        .TRST_N          (TRST_N),
        .TMS             (TMS),
        .TDI             (TDI),
        .TDO             (TDO),
        .tdo_en          (tdo_en),
        .user_capture    (user_capture),
        .user_update     (user_update),
        .user_update_stb (user_update_stb),
        .tap_state       (tap_state),
        .ir_q            (ir_q)
    );

    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One TCK cycle: sample TDO 2 units after negedge, then drive TMS/TDI
    // for the following posedge.
    task automatic tck(input logic tms_v, input logic tdi_v, output logic tdo_v);
        @(negedge TCK);
        #2;
        tdo_v = TDO;
        if (user_update_stb) stb_cnt++;
        TMS = tms_v;
        TDI = tdi_v;
        @(posedge TCK);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i], b);
            dout[i] = b;
        end
    endtask

    // Both scans start and end in Run-Test/Idle.
    task automatic irscan(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        tck(1, 0, b); tck(1, 0, b); tck(0, 0, b); tck(0, 0, b);
        shift_bits(n, din, dout);
        tck(1, 0, b); tck(0, 0, b);
        #1;
    endtask

    task automatic drscan(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        tck(1, 0, b); tck(0, 0, b); tck(0, 0, b);
        shift_bits(n, din, dout);
        tck(1, 0, b); tck(0, 0, b);
        #1;
    endtask

    initial begin
        TRST_N       = 1'b0;
        TMS          = 1'b1;
        TDI          = 1'b0;
        user_capture = 32'h1234_5678;
        repeat (3) @(posedge TCK);
        #1;
        check_val("rst_state", tap_state, TLR);
        check_val("rst_ir", ir_q, 4'h1);
        check_val("rst_tdo", TDO, 1'b0);
        check_val("rst_tdo_en", tdo_en, 1'b0);
        check_val("rst_user_update", user_update, 32'h0);
        check_val("rst_stb", user_update_stb, 1'b0);

        @(negedge TCK); #1 TRST_N = 1'b1;
        tck(0, 0, d);
        #1 check_val("to_rti", tap_state, RTI);

        drscan(32, 64'h0, rd);
        check_val("idcode_read", rd[31:0], 32'h10A5_E0CF);
        check_val("idcode_end_rti", tap_state, RTI);
        check_val("idcode_tdo_en_idle", tdo_en, 1'b0);

        irscan(4, 64'h1, rd);
        check_val("ir1_capture", rd[3:0], 4'h1);
        check_val("ir1_ir_q", ir_q, 4'h1);

        irscan(4, 64'hF, rd);
        check_val("irF_capture", rd[3:0], 4'h1);
        check_val("irF_ir_q", ir_q, 4'hF);
        stb_cnt = 0;
        drscan(8, 64'hA5, rd);
        check_val("bypass_read", rd[7:0], 8'h4A);
        check_val("bypass_no_stb", stb_cnt, 0);

        irscan(4, 64'h8, rd);
        check_val("ir8_ir_q", ir_q, 4'h8);
        stb_cnt = 0;
        drscan(32, 64'hDEAD_BEEF, rd);
        check_val("user_read", rd[31:0], 32'h1234_5678);
        check_val("user_update", user_update, 32'hDEAD_BEEF);
        check_val("user_stb_once", stb_cnt, 1);

        irscan(4, 64'h5, rd);
        check_val("ir5_ir_q", ir_q, 4'h5);
        stb_cnt = 0;
        drscan(4, 64'h3, rd);
        check_val("undef_bypass_read", rd[3:0], 4'h6);
        check_val("undef_no_stb", stb_cnt, 0);
        check_val("undef_user_hold", user_update, 32'hDEAD_BEEF);

        // Five TMS=1 cycles from Shift-DR must land in Test-Logic-Reset.
        tck(1, 0, d); tck(0, 0, d); tck(0, 0, d);
        #1 check_val("in_shift_dr", tap_state, SHIFT_DR);
        repeat (5) tck(1, 0, d);
        @(negedge TCK); #1;
        check_val("tms5_tlr", tap_state, TLR);
        check_val("tms5_ir_idcode", ir_q, 4'h1);

        // Fresh reset so user_update starts from a known value, then
        // interrupt a USER scan after 10 shift bits.
        TRST_N = 1'b0; #1 TRST_N = 1'b1;
        tck(0, 0, d);
        irscan(4, 64'h8, rd);
        check_val("ir8b_ir_q", ir_q, 4'h8);
        stb_cnt = 0;
        tck(1, 0, d); tck(0, 0, d); tck(0, 0, d);
        for (int i = 0; i < 10; i++) tck(0, 1'b1, d);
        @(negedge TCK); #1 TRST_N = 1'b0;
        #1;
        check_val("trst_state", tap_state, TLR);
        check_val("trst_ir", ir_q, 4'h1);
        check_val("trst_user_update", user_update, 32'h0);
        check_val("trst_tdo_en", tdo_en, 1'b0);
        check_val("trst_stb", user_update_stb, 1'b0);
        TMS = 1'b1;
        #1 TRST_N = 1'b1;
        repeat (5) tck(1, 0, d);
        #1;
        check_val("trst_tms5_tlr", tap_state, TLR);
        check_val("trst_no_stb", stb_cnt, 0);
        check_val("trst_user_final", user_update, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
